eqed_campaign_ctrl: RTL and testbench
=====================================

Name: eqed_campaign_ctrl

Overview:
- Sequencer for EQED single-bit-flip fault-injection campaigns on a design instrumented with inverting select muxes in front of each flip-flop.
- First runs the design fault-free from reset and captures the golden input and output MISR signatures.
- Then re-runs the design once per (flip-flop, injection cycle) pair:
  - drives a one-hot select for exactly one cycle;
  - compares the final output signature against golden;
  - counts detected and undetected injections.
- Sits beside the design under test. It drives the design's reset and select vector and observes the external MISRs.

Parameters:
- NUM_FF, 8: number of injectable flip-flops, which is the width of inj_sel.
- SIG_W, 6: MISR signature width.
- RST_CYC, 2: cycles dut_rst is held high at the start of every run. Must be ≥1.
- RUN_CYC, 5: post-reset cycles per run. Must be ≥ MAX_INJ_CYC.
- MAX_INJ_CYC, 4: injection cycles swept, 1..MAX_INJ_CYC.

Ports:
- clk  in  1  clock.
- rst  in  1  controller reset.
- start  in  1  campaign start request.
- in_sig  in  SIG_W  input-MISR signature.
- out_sig  in  SIG_W  output-MISR signature.
- dut_rst  out  1  reset to the DUT and both MISRs.
- inj_sel  out  NUM_FF  one-hot bit-flip select; all zero when not injecting.
- busy  out  1  campaign in progress.
- done  out  1  campaign complete; sticky until the next accepted start.
- result_valid  out  1  one-cycle pulse, one per injection run.
- result_ff  out  clog2(NUM_FF)  flip-flop index of the reported run.
- result_cyc  out  clog2(MAX_INJ_CYC+1)  injection cycle of the reported run.
- result_detected  out  1  out_sig differed from golden.
- detected_cnt  out  clog2(NUM_FF*MAX_INJ_CYC+1)  number of detected runs.
- undetected_cnt  out  same width  number of undetected runs.
- in_mismatch  out  1  sticky flag: in_sig differed from golden on some run.

Behaviour:
- Reset and default values:
  - rst is synchronous and active-high. It forces state IDLE from any state, including mid-run, and clears all counters, golden registers and flags.
  - Output values under reset: dut_rst=1, inj_sel=0, busy=0, done=0, result_valid=0, counts=0, in_mismatch=0.
- States: IDLE, GOLD_RST, GOLD_RUN, GOLD_CAP, INJ_RST, INJ_RUN, INJ_CMP, DONE.
- IDLE/DONE:
  - dut_rst=1, busy=0.
  - start=1 moves to GOLD_RST, clears counts, in_mismatch and done, and sets ff_idx=0, inj_cyc=1.
  - start is ignored in all other states.
- GOLD_RST / INJ_RST:
  - dut_rst=1 for exactly RST_CYC cycles, then move to *_RUN.
  - cyc_cnt loads to 1.
- GOLD_RUN / INJ_RUN:
  - dut_rst=0; cyc_cnt increments every cycle starting at 1.
  - When cyc_cnt==RUN_CYC, move to *_CAP / INJ_CMP.
- Injection:
  - In INJ_RUN, inj_sel = 1<<ff_idx combinationally-registered so it is high exactly in the cycle where cyc_cnt==inj_cyc; zero otherwise.
  - inj_sel is never nonzero in any GOLD state. Exactly one bit is set, for exactly one cycle per injection run.
- GOLD_CAP (1 cycle): register gold_in=in_sig and gold_out=out_sig, then move to INJ_RST.
- INJ_CMP (1 cycle):
  - result_valid=1 with result_ff=ff_idx, result_cyc=inj_cyc, result_detected=(out_sig!=gold_out).
  - Increment the matching count.
  - If in_sig!=gold_in, set in_mismatch.
- Advance after INJ_CMP:
  - ff_idx increments (inner loop). On wrap from NUM_FF-1, ff_idx=0 and inj_cyc increments (outer loop).
  - After pair (NUM_FF-1, MAX_INJ_CYC), move to DONE and set done=1; otherwise move to INJ_RST.
- busy=1 in every state except IDLE and DONE.
- Timing:
  - Every run (golden or injection) lasts RST_CYC+RUN_CYC+1 cycles.
  - With defaults, DONE is entered 8+32*8=264 edges after the edge sampling start.
- Invariant: detected_cnt+undetected_cnt equals the number of result_valid pulses, and never exceeds NUM_FF*MAX_INJ_CYC.

Test Plan:
- Defaults; start pulse; DUT stub holds in_sig=6'b111010, out_sig=6'b110010 constant.
  -> done rises 264 edges after start; detected_cnt=0, undetected_cnt=32, 32 result_valid pulses, in_mismatch=0.
- Injection timing check on the same run: first INJ_RUN.
  -> inj_sel=8'h01 only in its first cycle (cyc_cnt=1); next run inj_sel=8'h02.
  -> In run 9, inj_sel=8'h01 in the 2nd INJ_RUN cycle; inj_sel=0 throughout GOLD states.
- Stub flips out_sig to 6'b110011 at capture whenever it saw inj_sel[3] during that run.
  -> detected_cnt=4, undetected_cnt=28; result_detected=1 only when result_ff=3.
- Stub flips in_sig on the run with result_ff=5, result_cyc=2.
  -> in_mismatch=1 from that INJ_CMP through done; counts unaffected by in_sig.
- Assert rst for 1 cycle mid-INJ_RUN, while inj_sel is nonzero.
  -> next cycle: inj_sel=0, dut_rst=1, busy=0, counts=0; a new start reruns the full 264-cycle campaign.
- start pulsed repeatedly while busy.
  -> ignored; sequence and final counts are identical to the first scenario.

Source files
------------

// File: rtl/eqed_campaign_ctrl.sv
// EQED single-bit-flip campaign sequencer.
// The controller runs one fault-free golden run and captures both MISR signatures.
// It then performs one injection run per (flip-flop, injection cycle) pair and
// compares each final output signature against the golden one.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start, DUT held in reset
// GOLD_RST | DUT reset for RST_CYC cycles before the golden run
// GOLD_RUN | fault-free run, cyc_cnt counts 1..RUN_CYC
// GOLD_CAP | latch golden input/output signatures
// INJ_RST  | DUT reset for RST_CYC cycles before an injection run
// INJ_RUN  | run with a single one-cycle bit flip at cyc_cnt == inj_cyc
// INJ_CMP  | report result, update counts, advance (ff_idx, inj_cyc)
// DONE     | campaign finished, results held until the next start
module eqed_campaign_ctrl #(
    parameter int NUM_FF      = 8,
    parameter int SIG_W       = 6,
    parameter int RST_CYC     = 2,
    parameter int RUN_CYC     = 5,
    parameter int MAX_INJ_CYC = 4,
    localparam int FF_W  = (NUM_FF > 1) ? $clog2(NUM_FF) : 1,
    localparam int CYC_W = $clog2(MAX_INJ_CYC + 1),
    localparam int CNT_W = $clog2(NUM_FF * MAX_INJ_CYC + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [SIG_W-1:0]  i_in_sig,
    input  logic [SIG_W-1:0]  i_out_sig,
    output logic              o_dut_rst,
    output logic [NUM_FF-1:0] o_inj_sel,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_result_valid,
    output logic [FF_W-1:0]   o_result_ff,
    output logic [CYC_W-1:0]  o_result_cyc,
    output logic              o_result_detected,
    output logic [CNT_W-1:0]  o_detected_cnt,
    output logic [CNT_W-1:0]  o_undetected_cnt,
    output logic              o_in_mismatch
);

    localparam int RUN_W = $clog2(RUN_CYC + 1);
    localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_GOLD_RST, S_GOLD_RUN, S_GOLD_CAP,
        S_INJ_RST, S_INJ_RUN, S_INJ_CMP, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [RUN_W-1:0]   r_cyc_cnt;
    logic [FF_W-1:0]    r_ff_idx;
    logic [CYC_W-1:0]   r_inj_cyc;
    logic [SIG_W-1:0]   r_gold_in;
    logic [SIG_W-1:0]   r_gold_out;
    logic [CNT_W-1:0]   r_det_cnt;
    logic [CNT_W-1:0]   r_undet_cnt;
    logic               r_in_mismatch;

    logic               w_dut_rst;
    logic               w_busy;
    logic               w_valid;
    logic               w_rst_tc;
    logic               w_run_tc;
    logic               w_last_pair;
    logic               w_inj_hit;
    logic               w_out_diff;
    logic               w_in_diff;

    assign w_rst_tc    = (r_rst_cnt == '0);
    assign w_run_tc    = (r_cyc_cnt == RUN_W'(RUN_CYC));
    assign w_last_pair = (r_ff_idx == FF_W'(NUM_FF - 1)) && (r_inj_cyc == CYC_W'(MAX_INJ_CYC));
    assign w_inj_hit   = (r_state == S_INJ_RUN) && (r_cyc_cnt == RUN_W'(r_inj_cyc));
    assign w_out_diff  = (i_out_sig != r_gold_out);
    assign w_in_diff   = (i_in_sig != r_gold_in);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state control outputs
    always_comb begin
        w_state_nxt = r_state;
        w_dut_rst   = 1'b1;
        w_busy      = 1'b1;
        w_valid     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_busy = 1'b0;
                if (i_start) w_state_nxt = S_GOLD_RST;
            end
            S_GOLD_RST: begin
                if (w_rst_tc) w_state_nxt = S_GOLD_RUN;
            end
            S_GOLD_RUN: begin
                w_dut_rst = 1'b0;
                if (w_run_tc) w_state_nxt = S_GOLD_CAP;
            end
            S_GOLD_CAP: begin
                w_dut_rst   = 1'b0;
                w_state_nxt = S_INJ_RST;
            end
            S_INJ_RST: begin
                if (w_rst_tc) w_state_nxt = S_INJ_RUN;
            end
            S_INJ_RUN: begin
                w_dut_rst = 1'b0;
                if (w_run_tc) w_state_nxt = S_INJ_CMP;
            end
            S_INJ_CMP: begin
                w_dut_rst   = 1'b0;
                w_valid     = 1'b1;
                w_state_nxt = w_last_pair ? S_DONE : S_INJ_RST;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Run timers, sweep indices, golden signatures and result counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_cnt     <= '0;
            r_cyc_cnt     <= '0;
            r_ff_idx      <= '0;
            r_inj_cyc     <= '0;
            r_gold_in     <= '0;
            r_gold_out    <= '0;
            r_det_cnt     <= '0;
            r_undet_cnt   <= '0;
            r_in_mismatch <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_rst_cnt     <= RST_W'(RST_CYC - 1);
                        r_ff_idx      <= '0;
                        r_inj_cyc     <= CYC_W'(1);
                        r_det_cnt     <= '0;
                        r_undet_cnt   <= '0;
                        r_in_mismatch <= 1'b0;
                    end
                end
                S_GOLD_RST, S_INJ_RST: begin
                    if (!w_rst_tc) r_rst_cnt <= r_rst_cnt - RST_W'(1);
                    r_cyc_cnt <= RUN_W'(1);
                end
                S_GOLD_RUN, S_INJ_RUN: begin
                    if (!w_run_tc) r_cyc_cnt <= r_cyc_cnt + RUN_W'(1);
                end
                S_GOLD_CAP: begin
                    r_gold_in  <= i_in_sig;
                    r_gold_out <= i_out_sig;
                    r_rst_cnt  <= RST_W'(RST_CYC - 1);
                end
                S_INJ_CMP: begin
                    if (w_out_diff) r_det_cnt   <= r_det_cnt + CNT_W'(1);
                    else            r_undet_cnt <= r_undet_cnt + CNT_W'(1);
                    if (w_in_diff) r_in_mismatch <= 1'b1;
                    if (r_ff_idx == FF_W'(NUM_FF - 1)) begin
                        r_ff_idx  <= '0;
                        r_inj_cyc <= r_inj_cyc + CYC_W'(1);
                    end else begin
                        r_ff_idx <= r_ff_idx + FF_W'(1);
                    end
                    r_rst_cnt <= RST_W'(RST_CYC - 1);
                end
                default: begin
                end
            endcase
        end
    end

    // Reset overrides the decoded controls in the same cycle so the DUT never sees a flip under rst
    assign o_dut_rst         = w_dut_rst | rst;
    assign o_busy            = w_busy & ~rst;
    assign o_done            = (r_state == S_DONE) & ~rst;
    assign o_inj_sel         = (w_inj_hit && !rst) ? (NUM_FF'(1) << r_ff_idx) : '0;
    assign o_result_valid    = w_valid & ~rst;
    assign o_result_ff       = r_ff_idx;
    assign o_result_cyc      = r_inj_cyc;
    assign o_result_detected = w_valid & ~rst & w_out_diff;
    assign o_detected_cnt    = r_det_cnt;
    assign o_undetected_cnt  = r_undet_cnt;
    // The flag reads high already in the INJ_CMP cycle that first sees the difference
    assign o_in_mismatch     = r_in_mismatch | (w_valid & ~rst & w_in_diff);

endmodule

// File: tb/tb_eqed_campaign_ctrl.sv
// Bench for eqed_campaign_ctrl: MISR stub, timeline-level reference model, per-cycle compare.
module tb_eqed_campaign_ctrl;

    localparam int NUM_FF   = 8;
    localparam int SIG_W    = 6;
    localparam int RST_CYC  = 2;
    localparam int RUN_CYC  = 5;
    localparam int MAX_INJ  = 4;
    localparam int RUN_LEN  = RST_CYC + RUN_CYC + 1;
    localparam int N_RUNS   = NUM_FF * MAX_INJ;
    localparam int CAMP_LEN = RUN_LEN * (N_RUNS + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [SIG_W-1:0]  in_sig;
    logic [SIG_W-1:0]  out_sig;
    logic              dut_rst;
    logic [NUM_FF-1:0] inj_sel;
    logic              busy;
    logic              done;
    logic              rv;
    logic [2:0]        rff;
    logic [2:0]        rcyc;
    logic              rdet;
    logic [5:0]        dcnt;
    logic [5:0]        ucnt;
    logic              inmis;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;
    int mode    = 0;
    int m_mode  = 0;
    bit chk_en  = 1'b0;
    bit m_active = 1'b0;
    int m_t     = 0;

    eqed_campaign_ctrl dut (
        .clk(clk), .rst(rst), .i_start(start), .i_in_sig(in_sig), .i_out_sig(out_sig),
        .o_dut_rst(dut_rst), .o_inj_sel(inj_sel), .o_busy(busy), .o_done(done),
        .o_result_valid(rv), .o_result_ff(rff), .o_result_cyc(rcyc),
        .o_result_detected(rdet), .o_detected_cnt(dcnt), .o_undetected_cnt(ucnt),
        .o_in_mismatch(inmis)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    // DUT stub: flags what this run saw; cleared whenever the DUT is held in reset
    logic f3 = 1'b0;
    logic f5 = 1'b0;
    int   scyc = 0;
    always @(posedge clk) begin
        if (dut_rst) begin
            f3 <= 1'b0; f5 <= 1'b0; scyc <= 0;
        end else begin
            scyc <= scyc + 1;
            if (inj_sel[3]) f3 <= 1'b1;
            if (inj_sel[5] && scyc == 1) f5 <= 1'b1;
        end
    end
    assign out_sig = (mode == 1 && f3) ? 6'b110011 : 6'b110010;
    assign in_sig  = (mode == 2 && f5) ? 6'b111011 : 6'b111010;

    // Reference timeline: cycles elapsed since the start edge of the current campaign
    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0; m_t <= 0;
        end else if ((!m_active || m_t >= CAMP_LEN) && start) begin
            m_active <= 1'b1; m_t <= 0; m_mode <= mode;
        end else if (m_active && m_t < CAMP_LEN) begin
            m_t <= m_t + 1;
        end
    end

    function automatic bit run_det(int r);
        return (m_mode == 1) && ((r % NUM_FF) == 3);
    endfunction

    function automatic bit run_inmis(int r);
        return (m_mode == 2) && ((r % NUM_FF) == 5) && ((r / NUM_FF + 1) == 2);
    endfunction

    function automatic int cmp_time(int r);
        return RUN_LEN * (r + 1) + RUN_LEN - 1;
    endfunction

    logic       e_dut_rst, e_busy, e_done, e_rv, e_det, e_inmis;
    logic [7:0] e_inj;
    int         e_ff, e_cyc, e_dcnt, e_ucnt, mp, mr;

    // Compare DUT outputs to the model every cycle once out of the initial reset
    always @(negedge clk) begin
        if (chk_en) begin
            e_dut_rst = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rv = 1'b0; e_det = 1'b0;
            e_inmis = 1'b0; e_inj = 8'h00; e_ff = 0; e_cyc = 0; e_dcnt = 0; e_ucnt = 0;
            if (m_active) begin
                e_busy = (m_t < CAMP_LEN);
                e_done = !e_busy;
                if (m_t < CAMP_LEN) begin
                    mp = m_t % RUN_LEN;
                    mr = m_t / RUN_LEN - 1;
                    e_dut_rst = (mp < RST_CYC);
                    if (mr >= 0) begin
                        e_ff  = mr % NUM_FF;
                        e_cyc = mr / NUM_FF + 1;
                        if (mp >= RST_CYC && mp < RST_CYC + RUN_CYC && (mp - RST_CYC + 1) == e_cyc)
                            e_inj = 8'(1 << e_ff);
                        if (mp == RUN_LEN - 1) begin
                            e_rv = 1'b1; e_det = run_det(mr);
                        end
                    end
                end
                for (int r = 0; r < N_RUNS; r++) begin
                    if (cmp_time(r) < m_t) begin
                        if (run_det(r)) e_dcnt++; else e_ucnt++;
                    end
                    if (run_inmis(r) && cmp_time(r) <= m_t) e_inmis = 1'b1;
                end
            end
            if (rst) begin
                chk("rst_dut_rst", dut_rst, 1);
                chk("rst_inj_sel", inj_sel, 0);
                chk("rst_busy", busy, 0);
                chk("rst_valid", rv, 0);
                chk("rst_done", done, 0);
            end else begin
                chk("dut_rst", dut_rst, e_dut_rst);
                chk("inj_sel", inj_sel, e_inj);
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                chk("result_valid", rv, e_rv);
                chk("detected_cnt", dcnt, e_dcnt);
                chk("undetected_cnt", ucnt, e_ucnt);
                chk("in_mismatch", inmis, e_inmis);
                if (e_rv) begin
                    chk("result_ff", rff, e_ff);
                    chk("result_cyc", rcyc, e_cyc);
                    chk("result_detected", rdet, e_det);
                end
                if (m_active && m_mode == 0 && m_t == 10) chk("lit_inj_run0", inj_sel, 8'h01);
                if (m_active && m_mode == 0 && m_t == 18) chk("lit_inj_run1", inj_sel, 8'h02);
                if (m_active && m_mode == 0 && m_t == 75) chk("lit_inj_run9", inj_sel, 8'h01);
            end
            if (rv) n_pulse++;
        end
    end

    task automatic run_campaign(input int md, input bit pulse, input int exp_det, input int exp_undet);
        int p0;
        int lat;
        @(posedge clk); #1;
        mode = md; start = 1'b1; p0 = n_pulse;
        @(posedge clk); #1;
        start = 1'b0; lat = 0;
        for (int i = 1; i <= CAMP_LEN + 20; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
            if (pulse && i < CAMP_LEN - 10) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
        end
        start = 1'b0;
        chk("done_latency", lat, CAMP_LEN);
        @(negedge clk);
        chk("final_detected", dcnt, exp_det);
        chk("final_undetected", ucnt, exp_undet);
        chk("final_pulses", n_pulse - p0, N_RUNS);
        chk("final_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_dut_rst", dut_rst, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_counts", {dcnt, ucnt}, 0);
        chk("reset_inmis", inmis, 0);

        run_campaign(0, 1'b0, 0, 32);
        chk("plain_inmis", inmis, 0);

        run_campaign(1, 1'b0, 4, 28);

        run_campaign(2, 1'b0, 0, 32);
        chk("inmis_sticky", inmis, 1);

        // Reset in the first INJ_RUN cycle of run 5 (ff 5, cycle 1)
        @(posedge clk); #1;
        mode = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("pre_rst_inj_sel", inj_sel, 8'h20);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_inj_sel", inj_sel, 0);
        chk("post_rst_dut_rst", dut_rst, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_undet", ucnt, 0);
        chk("post_rst_det", dcnt, 0);
        run_campaign(0, 1'b0, 0, 32);

        run_campaign(0, 1'b1, 0, 32);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
